// File: rtl/crp_mem_if.sv
// crp_mem_if: CRP core memory request bus between the CPU and the memory responder
interface crp_mem_if;
    logic [14:0] memReqBus;
    logic        memWriteReq;
    logic [7:0]  memReadBus;
    modport master (output memReqBus, output memWriteReq, input memReadBus);
    modport slave (input memReqBus, input memWriteReq, output memReadBus);
endinterface

// File: rtl/crp_mem_responder.sv
// crp_mem_responder: byte RAM plus one I/O byte serving the CRP memory bus, 1-cycle read latency
module crp_mem_responder #(
    parameter int          DEPTH   = 256,
    parameter logic [14:0] IO_ADDR = 15'h7FFF
) (
    input  logic       clk,
    input  logic       reset,
    crp_mem_if.slave   bus,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {ADDR, WDATA} state_t;
    state_t      state, state_nx;
    logic [14:0] wr_addr;
    logic [7:0]  ram [DEPTH];
    logic [7:0]  rd_data;
    logic        rd_en, latch_addr, ram_we, io_we;
    always_comb begin
        state_nx   = (state == ADDR && bus.memWriteReq) ? WDATA : ADDR;
        rd_en      = state == ADDR && !bus.memWriteReq;
        latch_addr = state == ADDR && bus.memWriteReq;
        ram_we     = state == WDATA && wr_addr < 15'(DEPTH) && !reset;
        io_we      = state == WDATA && wr_addr == IO_ADDR;
        rd_data    = bus.memReqBus < 15'(DEPTH) ? ram[bus.memReqBus[AW-1:0]] :
                     bus.memReqBus == IO_ADDR   ? io_in : 8'hFF;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ADDR;
            bus.memReadBus <= 8'h00;
            io_out         <= 8'h00;
            wr_addr        <= '0;
        end else begin
            state <= state_nx;
            if (rd_en) bus.memReadBus <= rd_data;
            if (latch_addr) wr_addr <= bus.memReqBus;
            if (io_we) io_out <= bus.memReqBus[7:0];
        end
    end
    // RAM is deliberately outside the reset domain; reset only gates the write strobe
    always_ff @(posedge clk) begin
        if (ram_we) ram[wr_addr[AW-1:0]] <= bus.memReqBus[7:0];
    end
endmodule

// File: doc/crp_mem_responder.md
# crp_mem_responder

Memory-side responder for the CRP core's memory request bus. It sits across the bus from the CPU and serves its requests. It decodes memReqBus/memWriteReq, performs reads and writes on an internal byte RAM, and exposes one memory-mapped I/O byte. It returns read data on memReadBus with fixed one-cycle latency. It is used in simulation and FPGA bring-up, and as the on-chip memory when the core runs without external SRAM.

## Interface

- DEPTH, 256: number of RAM bytes, mapped at addresses 0 .. DEPTH-1. Must be a power of two, 2..16384.
- IO_ADDR, 15'h7FFF: address of the I/O byte. Must be ≥ DEPTH.

- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset (the core's reset, i.e. ~rst_n at top level).
- memReqBus  input  15  address in an address cycle; bits [7:0] carry write data in a write-data cycle.
- memWriteReq  input  1  high in an address cycle marks a write; the next cycle is the write-data cycle.
- memReadBus  output  8  read data returned to the core; registered.
- io_in  input  8  external input byte, returned on a read of IO_ADDR.
- io_out  output  8  external output byte, written by a write to IO_ADDR; registered.

## Operation

- FSM, two states:
  - ADDR: reset state; every cycle here is an address cycle.
  - WDATA: entered for exactly one cycle after a write address cycle.
- ADDR, memWriteReq=0 (read):
  - addr < DEPTH: memReadBus <= ram[addr[log2(DEPTH)-1:0]].
  - addr == IO_ADDR: memReadBus <= io_in, sampled this cycle.
  - Any other address: memReadBus <= 8'hFF.
  - Stay in ADDR.
- ADDR, memWriteReq=1 (write address): latch addr into wr_addr, go to WDATA. memReadBus holds its value.
- WDATA:
  - data = memReqBus[7:0]; memReqBus[14:8] and memWriteReq are ignored.
  - wr_addr < DEPTH: ram[wr_addr] <= data.
  - wr_addr == IO_ADDR: io_out <= data.
  - Any other address: write dropped, no side effect.
  - memReadBus holds. Return to ADDR.
- Address decode uses the full 15 bits. No aliasing above DEPTH.
- RAM contents are not cleared by reset. Reads of never-written locations are X in simulation; benches must not check them.

## Timing

- Reset (sampled high at an edge) sets:
  - state = ADDR
  - memReadBus = 8'h00
  - io_out = 8'h00
  - wr_addr = 0
- Reset overrides everything. A reset asserted in WDATA aborts the write: RAM and io_out are unchanged except io_out is forced to 0.
- Read latency is 1 cycle. Address presented in cycle N; data is valid on memReadBus after edge N and holds until the next read address cycle completes.
- A write takes 2 cycles: address cycle N, data cycle N+1. RAM/io_out update at edge N+1.
- Read-after-write: a read of the same address in cycle N+2 returns the new data after edge N+2.
- Back-to-back writes are legal: ADDR(w), WDATA, ADDR(w), WDATA, ...
- memWriteReq=1 during WDATA does not start a new write. The cycle after WDATA is always an address cycle.
- io_in is sampled at the read edge only. There is no synchronizer inside; the top level provides one if needed.
- No stall or wait states. The responder accepts a request every address cycle.

## Test plan

- Reset: hold reset 2 cycles, then release -> memReadBus=8'h00, io_out=8'h00. A write address cycle with reset high leaves the FSM in ADDR, so the next cycle is treated as an address cycle.
- Write/read RAM: write 8'hA5 to 15'h0010 (addr cycle, then data cycle), read 15'h0010 next cycle -> memReadBus=8'hA5 one cycle after the read address.
- Out-of-range: write 8'h3C to 15'h0100 with DEPTH=256, then read 15'h0000 and 15'h0100 -> ram[0] unchanged; read of 0x0100 returns 8'hFF.
- I/O: write 8'h5A to 15'h7FFF -> io_out=8'h5A after the data-cycle edge. Set io_in=8'hC3 and read 15'h7FFF -> memReadBus=8'hC3.
- Back-to-back writes with memWriteReq held high through both data cycles: write 8'h11 to addr 1, then 8'h22 to addr 2 -> reads return 8'h11 and 8'h22. In each data cycle, memReqBus[14:8] is not taken as an address.
- Reset mid-write: write address 15'h0005 (ram[5] preloaded 8'h77), assert reset in the data cycle with data 8'hEE -> ram[5] reads 8'h77 after reset releases.
